// File: rtl/audio_cfg_pkg.sv
// audio_cfg_pkg
// Shared definitions for the audio filter coefficient configuration block:
// shadow word addresses, the coefficient set structure, the default set
// loaded at reset or on request, and the swap sequencer state encoding.
package audio_cfg_pkg;

    // Shadow word address map
    localparam logic [3:0] ADDR_RATE_LO = 4'd0;
    localparam logic [3:0] ADDR_RATE_HI = 4'd1;
    localparam logic [3:0] ADDR_CX_LO   = 4'd2;
    localparam logic [3:0] ADDR_CX_MID  = 4'd3;
    localparam logic [3:0] ADDR_CX_HI   = 4'd4;
    localparam logic [3:0] ADDR_CX01    = 4'd5;
    localparam logic [3:0] ADDR_CX2     = 4'd6;
    localparam logic [3:0] ADDR_CY0_LO  = 4'd7;
    localparam logic [3:0] ADDR_CY0_HI  = 4'd8;
    localparam logic [3:0] ADDR_CY1_LO  = 4'd9;
    localparam logic [3:0] ADDR_CY1_HI  = 4'd10;
    localparam logic [3:0] ADDR_CY2_LO  = 4'd11;
    localparam logic [3:0] ADDR_CY2_HI  = 4'd12;

    // One complete IIR coefficient set
    typedef struct packed {
        logic [31:0] rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } coef_set_t;

    // Default coefficient set (cy values are 24-bit two's complement)
    localparam logic [31:0] DEF_RATE = 32'd7056000;
    localparam logic [39:0] DEF_CX   = 40'd4258969;
    localparam logic [7:0]  DEF_CX0  = 8'd3;
    localparam logic [7:0]  DEF_CX1  = 8'd3;
    localparam logic [7:0]  DEF_CX2  = 8'd1;
    localparam logic [23:0] DEF_CY0  = -24'sd6216759;
    localparam logic [23:0] DEF_CY1  = 24'sd6143386;
    localparam logic [23:0] DEF_CY2  = -24'sd2023767;

    localparam coef_set_t DEF_SET = '{
        rate: DEF_RATE, cx: DEF_CX,
        cx0: DEF_CX0, cx1: DEF_CX1, cx2: DEF_CX2,
        cy0: DEF_CY0, cy1: DEF_CY1, cy2: DEF_CY2
    };

    // Swap sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_LOAD,
        ST_POST
    } state_t;

endpackage

// File: rtl/audio_flt_cfg.sv
// audio_flt_cfg
// Coefficient shadow register bank with a glitch-free swap sequencer for an
// IIR audio output filter. Software writes the shadow set word by word, then
// commits; the sequencer holds the filter in reset (areset) for RST_CYCLES
// cycles, copies shadow to active in a single LOAD cycle, and holds reset for
// another RST_CYCLES cycles before releasing it.
//
// Ports
//   clk_audio              single clock
//   reset_n                synchronous active-low reset
//   cfg_wr/addr/data       shadow word write (16 bits per cycle)
//   cfg_commit             pulse: start a swap of shadow -> active
//   cfg_default            pulse: load default set into shadow, then commit
//   busy                   sequencer not idle
//   cfg_err                one-cycle pulse: commit rejected (shadow rate 0)
//   areset                 reset request to the filter datapath
//   flt_rate, cx, cx0..2, cy0..2   active coefficient set
module audio_flt_cfg
    import audio_cfg_pkg::*;
#(
    parameter int RST_CYCLES = 16
) (
    input  logic        clk_audio,
    input  logic        reset_n,
    input  logic        cfg_wr,
    input  logic [3:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic        cfg_commit,
    input  logic        cfg_default,
    output logic        busy,
    output logic        cfg_err,
    output logic        areset,
    output logic [31:0] flt_rate,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2
);

    localparam logic [7:0] CNT_LAST = 8'(RST_CYCLES - 1);

    state_t    state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic      pending_reg, pending_next;
    logic      cfg_err_reg, cfg_err_next;
    logic      areset_reg;
    logic      load_en;
    logic      commit_req;
    logic      rate_ok;
    coef_set_t shadow_reg;
    coef_set_t active_reg;

    // A default request is also a commit. Its rate check uses the default
    // set (never zero), because the shadow is overwritten on the same edge.
    assign commit_req = cfg_commit | cfg_default;
    assign rate_ok    = cfg_default | (shadow_reg.rate != 32'd0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pending_next = pending_reg;
        cfg_err_next = 1'b0;
        load_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (commit_req || pending_reg) begin
                    pending_next = 1'b0;
                    if (rate_ok) begin
                        state_next = ST_PRE;
                        cnt_next   = 8'd0;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (commit_req) pending_next = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_LOAD;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_LOAD: begin
                if (commit_req) pending_next = 1'b1;
                load_en    = 1'b1;
                state_next = ST_POST;
                cnt_next   = 8'd0;
            end
            ST_POST: begin
                if (commit_req) pending_next = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Sequencer state; areset is registered from the next state so it is a
    // clean flop output tracking "not idle".
    always_ff @(posedge clk_audio) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 8'd0;
            pending_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
            areset_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            cfg_err_reg <= cfg_err_next;
            areset_reg  <= (state_next != ST_IDLE);
        end
    end

    // Shadow bank. A default request overrides any same-cycle word write.
    always_ff @(posedge clk_audio) begin
        if (!reset_n || cfg_default) begin
            shadow_reg <= DEF_SET;
        end else if (cfg_wr) begin
            case (cfg_addr)
                ADDR_RATE_LO: shadow_reg.rate[15:0]  <= cfg_data;
                ADDR_RATE_HI: shadow_reg.rate[31:16] <= cfg_data;
                ADDR_CX_LO:   shadow_reg.cx[15:0]    <= cfg_data;
                ADDR_CX_MID:  shadow_reg.cx[31:16]   <= cfg_data;
                ADDR_CX_HI:   shadow_reg.cx[39:32]   <= cfg_data[7:0];
                ADDR_CX01: begin
                    shadow_reg.cx0 <= cfg_data[7:0];
                    shadow_reg.cx1 <= cfg_data[15:8];
                end
                ADDR_CX2:     shadow_reg.cx2         <= cfg_data[7:0];
                ADDR_CY0_LO:  shadow_reg.cy0[15:0]   <= cfg_data;
                ADDR_CY0_HI:  shadow_reg.cy0[23:16]  <= cfg_data[7:0];
                ADDR_CY1_LO:  shadow_reg.cy1[15:0]   <= cfg_data;
                ADDR_CY1_HI:  shadow_reg.cy1[23:16]  <= cfg_data[7:0];
                ADDR_CY2_LO:  shadow_reg.cy2[15:0]   <= cfg_data;
                ADDR_CY2_HI:  shadow_reg.cy2[23:16]  <= cfg_data[7:0];
                default: ;
            endcase
        end
    end

    // Active set changes only at the end of LOAD; a write landing in that
    // same cycle reaches the shadow after the copy has taken the old value.
    always_ff @(posedge clk_audio) begin
        if (!reset_n) begin
            active_reg <= DEF_SET;
        end else if (load_en) begin
            active_reg <= shadow_reg;
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign cfg_err  = cfg_err_reg;
    assign areset   = areset_reg;
    assign flt_rate = active_reg.rate;
    assign cx       = active_reg.cx;
    assign cx0      = active_reg.cx0;
    assign cx1      = active_reg.cx1;
    assign cx2      = active_reg.cx2;
    assign cy0      = active_reg.cy0;
    assign cy1      = active_reg.cy1;
    assign cy2      = active_reg.cy2;

endmodule

// File: tb/tb_audio_flt_cfg.sv
// tb_audio_flt_cfg
// Directed bench for audio_flt_cfg (RST_CYCLES = 16). A bench-side model of
// the shadow set is snapshotted into a queue in the LOAD cycle and popped
// when the new active set should appear on the outputs.
module tb_audio_flt_cfg;

    typedef struct packed {
        logic [31:0] rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } set_t;

    localparam set_t DEF = '{
        rate: 32'd7056000, cx: 40'd4258969,
        cx0: 8'd3, cx1: 8'd3, cx2: 8'd1,
        cy0: 24'd10560457, cy1: 24'd6143386, cy2: 24'd14753449
    };

    logic        clk_audio = 1'b0;
    logic        reset_n   = 1'b0;
    logic        cfg_wr    = 1'b0;
    logic [3:0]  cfg_addr  = 4'd0;
    logic [15:0] cfg_data  = 16'd0;
    logic        cfg_commit  = 1'b0;
    logic        cfg_default = 1'b0;
    logic        busy, cfg_err, areset;
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;

    int   total = 0;
    int   bad   = 0;
    set_t tb_shadow;
    set_t tb_active;
    set_t exp_q[$];

    audio_flt_cfg #(.RST_CYCLES(16)) dut (
        .clk_audio(clk_audio), .reset_n(reset_n),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_default(cfg_default),
        .busy(busy), .cfg_err(cfg_err), .areset(areset),
        .flt_rate(flt_rate), .cx(cx), .cx0(cx0), .cx1(cx1), .cx2(cx2),
        .cy0(cy0), .cy1(cy1), .cy2(cy2)
    );

    always #5 clk_audio = ~clk_audio;

    function automatic set_t observed();
        return {flt_rate, cx, cx0, cx1, cx2, cy0, cy1, cy2};
    endfunction

    task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_audio);
        #1;
    endtask

    task automatic clear_strobes();
        cfg_wr = 1'b0;
        cfg_commit = 1'b0;
        cfg_default = 1'b0;
    endtask

    task automatic model_wr(input logic [3:0] a, input logic [15:0] d);
        case (a)
            4'd0:  tb_shadow.rate[15:0]  = d;
            4'd1:  tb_shadow.rate[31:16] = d;
            4'd2:  tb_shadow.cx[15:0]    = d;
            4'd3:  tb_shadow.cx[31:16]   = d;
            4'd4:  tb_shadow.cx[39:32]   = d[7:0];
            4'd5:  begin tb_shadow.cx0 = d[7:0]; tb_shadow.cx1 = d[15:8]; end
            4'd6:  tb_shadow.cx2         = d[7:0];
            4'd7:  tb_shadow.cy0[15:0]   = d;
            4'd8:  tb_shadow.cy0[23:16]  = d[7:0];
            4'd9:  tb_shadow.cy1[15:0]   = d;
            4'd10: tb_shadow.cy1[23:16]  = d[7:0];
            4'd11: tb_shadow.cy2[15:0]   = d;
            4'd12: tb_shadow.cy2[23:16]  = d[7:0];
            default: ;
        endcase
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        model_wr(a, d);
        tick();
        clear_strobes();
    endtask

    // Called in the cycle where a commit is presented (or pending in IDLE).
    // Checks offsets 1..34; optionally drives a write at wr_k and a commit at cm_k.
    task automatic watch_seq(input string name, input int wr_k, input logic [3:0] a,
                             input logic [15:0] d, input int cm_k);
        for (int k = 1; k <= 34; k++) begin
            tick();
            clear_strobes();
            if (k == 18) tb_active = exp_q.pop_front();
            chk($sformatf("%s areset k=%0d", name, k), 168'(areset), 168'(k <= 33));
            chk($sformatf("%s busy k=%0d", name, k), 168'(busy), 168'(k <= 33));
            chk($sformatf("%s coef k=%0d", name, k), observed(), tb_active);
            if (k == 17) exp_q.push_back(tb_shadow);
            if (k == wr_k) begin
                cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
                model_wr(a, d);
            end
            if (k == cm_k) cfg_commit = 1'b1;
        end
    endtask

    initial begin
        tb_shadow = DEF;
        tb_active = DEF;

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        chk("rst coef", observed(), DEF);
        chk("rst areset", 168'(areset), 168'(0));
        chk("rst busy", 168'(busy), 168'(0));
        chk("rst cfg_err", 168'(cfg_err), 168'(0));
        tick();
        chk("rst idle coef", observed(), DEF);

        // Rate 48000, single sequence
        wr(4'd0, 16'hBB80);
        wr(4'd1, 16'h0000);
        cfg_commit = 1'b1;
        watch_seq("rate48k", -1, 4'd0, 16'd0, -1);
        chk("rate48k flt_rate", 168'(flt_rate), 168'(48000));
        $display("txn rate48k done: flt_rate=%0d", flt_rate);

        // Rate zero: commit rejected
        wr(4'd1, 16'h0000);
        wr(4'd0, 16'h0000);
        cfg_commit = 1'b1;
        tick();
        clear_strobes();
        chk("err pulse", 168'(cfg_err), 168'(1));
        chk("err areset", 168'(areset), 168'(0));
        chk("err busy", 168'(busy), 168'(0));
        tick();
        chk("err pulse end", 168'(cfg_err), 168'(0));
        chk("err areset2", 168'(areset), 168'(0));
        chk("err coef", observed(), tb_active);
        $display("txn rate0 commit rejected: cfg_err checked");

        // Pending commit during PRE plus a cy2 write; ignored address 13
        wr(4'd0, 16'h5622);
        wr(4'd13, 16'hFFFF);
        wr(4'd9, 16'hABCD);
        cfg_commit = 1'b1;
        watch_seq("pend1", 8, 4'd11, 16'h1234, 5);
        watch_seq("pend2", -1, 4'd0, 16'd0, -1);
        chk("pend cy2 lo", 168'(cy2[15:0]), 168'(16'h1234));
        $display("txn pending back-to-back done: cy2=%0h", cy2);

        // Write in LOAD cycle lands after the copy
        cfg_commit = 1'b1;
        watch_seq("ldwr1", 17, 4'd6, 16'h0007, -1);
        cfg_commit = 1'b1;
        watch_seq("ldwr2", -1, 4'd0, 16'd0, -1);
        chk("ldwr cx2", 168'(cx2), 168'(7));
        $display("txn load-cycle write done: cx2=%0d", cx2);

        // Default + commit + write together: one sequence, write dropped
        cfg_default = 1'b1; cfg_commit = 1'b1;
        cfg_wr = 1'b1; cfg_addr = 4'd0; cfg_data = 16'h1111;
        tb_shadow = DEF;
        watch_seq("dflt", -1, 4'd0, 16'd0, -1);
        tick();
        chk("dflt single seq busy", 168'(busy), 168'(0));
        chk("dflt coef", observed(), DEF);
        $display("txn default load done: flt_rate=%0d", flt_rate);

        // Reset during POST aborts and restores defaults
        wr(4'd5, 16'h5555);
        cfg_commit = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            clear_strobes();
        end
        chk("post areset", 168'(areset), 168'(1));
        chk("post coef", observed(), tb_shadow);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tb_shadow = DEF;
        tb_active = DEF;
        chk("abort areset", 168'(areset), 168'(0));
        chk("abort busy", 168'(busy), 168'(0));
        chk("abort coef", observed(), DEF);
        tick();
        chk("abort idle busy", 168'(busy), 168'(0));
        chk("abort idle areset", 168'(areset), 168'(0));
        $display("txn reset in POST done: areset=%0b busy=%0b", areset, busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_flt_cfg.md
AUDIO_FLT_CFG -- requirements
Module: audio_flt_cfg

Interface
REQ-001 Parameter RST_CYCLES, default 16, cycles of areset before and after a coefficient swap (legal range 1..255).
REQ-002 clk_audio  input  1  single clock for all logic.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk_audio.
REQ-004 cfg_wr  input  1  write strobe: one 16-bit shadow word per asserted cycle.
REQ-005 cfg_addr  input  4  shadow word address.
REQ-006 cfg_data  input  16  shadow write data.
REQ-007 cfg_commit  input  1  single-cycle pulse: transfer shadow set to active outputs.
REQ-008 cfg_default  input  1  single-cycle pulse: load default set into shadow, then commit.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 cfg_err  output  1  one-cycle pulse: commit rejected.
REQ-011 areset  output  1  filter reset request to the audio output datapath.
REQ-012 flt_rate  output  32 / cx  output  40 / cx0, cx1, cx2  output  8 each / cy0, cy1, cy2  output  24 each  active IIR coefficient set.

Function
REQ-013 Address map: 0 rate[15:0]; 1 rate[31:16]; 2 cx[15:0]; 3 cx[31:16]; 4 cx[39:32] from data[7:0]; 5 cx0=data[7:0], cx1=data[15:8]; 6 cx2=data[7:0]; 7 cy0[15:0]; 8 cy0[23:16]; 9 cy1[15:0]; 10 cy1[23:16]; 11 cy2[15:0]; 12 cy2[23:16].
REQ-014 Writes to addresses 13-15 are ignored; unused data bits are ignored.
REQ-015 Default set: rate 7056000, cx 4258969, cx0 3, cx1 3, cx2 1, cy0 -6216759, cy1 6143386, cy2 -2023767 (24-bit two's complement).
REQ-016 Shadow writes are accepted in every state, including while busy.
REQ-017 FSM states: IDLE, PRE, LOAD, POST.
REQ-018 IDLE -> PRE on a commit (fresh or pending); areset=1 from the next cycle.
REQ-019 PRE holds for RST_CYCLES cycles -> LOAD.
REQ-020 LOAD lasts one cycle and copies shadow to active; new outputs are visible on the following cycle.
REQ-021 POST holds areset=1 for RST_CYCLES cycles -> IDLE; areset=0 and busy=0 on IDLE entry.
REQ-022 Latency: commit sampled at cycle T gives areset high from T+1, active change at T+2+RST_CYCLES, areset low at T+2+2*RST_CYCLES.
REQ-023 Active outputs never change except at LOAD.
REQ-024 A commit while busy sets a single pending flag; further commits while pending are merged; pending starts a new PRE immediately after POST with no IDLE dwell beyond one cycle.
REQ-025 A shadow write in the LOAD cycle updates the shadow after the copy, so LOAD copies the pre-write value.
REQ-026 On commit acceptance in IDLE, if shadow rate == 0: no sequence, and cfg_err pulses one cycle later.
REQ-027 cfg_default with cfg_commit in the same cycle: default wins, giving one sequence.
REQ-028 cfg_default with cfg_wr in the same cycle: the default load wins and the write is dropped.
REQ-029 cfg_default while busy loads the shadow immediately and sets pending.

Reset
REQ-030 reset_n low, synchronous: state IDLE, pending 0, busy 0, cfg_err 0, areset 0, shadow and active = default set, counter 0.
REQ-031 reset_n low mid-sequence aborts it; active returns to defaults; there is no glitch on areset beyond the cycle reset is sampled.

Structure
REQ-032 Shared package audio_cfg_pkg holds address constants, default coefficient constants and the FSM state enum.
REQ-033 No sub-module; a single counter is shared by PRE and POST.

Verification
REQ-034 Reset, then read outputs -> defaults per REQ-015, areset=0, busy=0.
REQ-035 Write rate 48000 (addr 0=0xBB80, 1=0x0000), commit at T, RST_CYCLES=16 -> areset high T+1..T+33, flt_rate=48000 from T+18, busy low at T+34.
REQ-036 Write addr 1=0 and addr 0=0, commit -> cfg_err pulse, areset stays 0, outputs unchanged.
REQ-037 Commit, then a second commit and a write cy2 lo=0x1234 during PRE -> two back-to-back sequences; cy2[15:0]=0x1234 after the second.
REQ-038 Write cx2=7 in the LOAD cycle -> active cx2 is the old value after the first sequence and 7 after the next commit.
REQ-039 reset_n low during POST -> next cycle IDLE, areset=0, defaults on outputs.
